// File: rtl/mx_xgbe_port_ctrl.sv
// SFP+/PHY port sequencer: synchronise and debounce the status pins, sequence tx_disable/nreset, drive the LEDs.
// All outputs are registered. Macro MX_XGBE_PORT_CTRL_FAULT_RETRY_EN selects timed FAULT retry over sticky FAULT.
module mx_xgbe_port_ctrl #(
    parameter int DEB_CYCLES = 1024,
    parameter int RST_CYCLES = 256,
    parameter int FAULT_HOLD = 65536,
    parameter int LED_HOLD   = 4096
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       mod_abs_i,
    input  logic       rx_los_i,
    input  logic       tx_fault_i,
    input  logic       lopc_i,
    input  logic       sw_tx_disable_i,
    input  logic       sw_reset_i,
    input  logic       rx_pkt_i,
    output logic       tx_disable_o,
    output logic       xge_nreset_o,
    output logic       gbe_nreset_o,
    output logic       gbe_coma_o,
    output logic       alrm_led_o,
    output logic       rx_led_o,
    output logic       mod_abs_o,
    output logic       rx_los_o,
    output logic       tx_fault_o,
    output logic       lopc_o,
    output logic [2:0] state_o,
    output logic [7:0] fault_cnt_o
);

    localparam logic [2:0] ST_ABSENT = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_RESET  = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

`ifdef MX_XGBE_PORT_CTRL_FAULT_RETRY_EN
    localparam int TMR_MAX = (FAULT_HOLD > RST_CYCLES) ? FAULT_HOLD : RST_CYCLES;
`else
    // Sticky FAULT needs no hold timer, so FAULT_HOLD does not widen the state timer.
    localparam int TMR_MAX = (FAULT_HOLD > 0) ? RST_CYCLES : RST_CYCLES;
`endif
    localparam int DEB_W = $clog2(DEB_CYCLES);
    localparam int TMR_W = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int LED_W = $clog2(LED_HOLD + 1);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYCLES - 1);
`ifdef MX_XGBE_PORT_CTRL_FAULT_RETRY_EN
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(FAULT_HOLD - 1);
`endif
    localparam logic [LED_W-1:0] LED_LOAD = LED_W'(LED_HOLD);
    // Bit order {lopc, tx_fault, rx_los, mod_abs}; reset reads as "no module, no link".
    localparam logic [3:0] DEB_INIT = 4'b1011;

    logic [3:0] raw;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] deb;

    assign raw = {lopc_i, tx_fault_i, rx_los_i, mod_abs_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1 <= DEB_INIT;
            sync2 <= DEB_INIT;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_deb
        logic [DEB_W-1:0] cnt;
        logic             q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt <= '0;
                q   <= DEB_INIT[g];
            end else if (sync2[g] == q) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                cnt <= '0;
                q   <= sync2[g];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign deb[g] = q;
    end

    assign mod_abs_o  = deb[0];
    assign rx_los_o   = deb[1];
    assign tx_fault_o = deb[2];
    assign lopc_o     = deb[3];

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [TMR_W-1:0] tmr;
    logic             tmr_clr;
    logic             tmr_run;
    logic             fault_q;
    logic             fault_evt;

    always_comb begin
        state_nxt = state;
        tmr_clr   = 1'b0;
        fault_evt = 1'b0;
        if (mod_abs_o) begin
            state_nxt = ST_ABSENT;
        end else begin
            case (state)
                ST_ABSENT: state_nxt = ST_SETTLE;
                ST_SETTLE: if (tmr == RST_LAST) state_nxt = ST_RESET;
                ST_RESET: begin
                    if (sw_reset_i)            tmr_clr   = 1'b1;
                    else if (tmr == RST_LAST)  state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (tx_fault_o && !fault_q) begin
                        state_nxt = ST_FAULT;
                        fault_evt = 1'b1;
                    end else if (sw_reset_i) begin
                        state_nxt = ST_RESET;
                    end
                end
`ifdef MX_XGBE_PORT_CTRL_FAULT_RETRY_EN
                ST_FAULT: if (tmr == HOLD_LAST) state_nxt = ST_RESET;
`else
                ST_FAULT: if (sw_reset_i) state_nxt = ST_RESET;
`endif
                default: state_nxt = ST_ABSENT;
            endcase
        end
    end

`ifdef MX_XGBE_PORT_CTRL_FAULT_RETRY_EN
    assign tmr_run = (state == ST_SETTLE) || (state == ST_RESET) || (state == ST_FAULT);
`else
    assign tmr_run = (state == ST_SETTLE) || (state == ST_RESET);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_ABSENT;
            tmr         <= '0;
            fault_q     <= 1'b0;
            fault_cnt_o <= 8'd0;
        end else begin
            state   <= state_nxt;
            fault_q <= tx_fault_o;
            if ((state_nxt != state) || tmr_clr)
                tmr <= '0;
            else if (tmr_run)
                tmr <= tmr + 1'b1;
            if (fault_evt && (fault_cnt_o != 8'hFF))
                fault_cnt_o <= fault_cnt_o + 8'd1;
        end
    end

    assign state_o = state;

    // Pin drives follow the registered state, one cycle behind it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_disable_o <= 1'b1;
            xge_nreset_o <= 1'b0;
            gbe_nreset_o <= 1'b0;
            gbe_coma_o   <= 1'b1;
            alrm_led_o   <= 1'b0;
        end else begin
            tx_disable_o <= ((state == ST_RESET) || (state == ST_RUN)) ? sw_tx_disable_i : 1'b1;
            xge_nreset_o <= (state == ST_RUN) || (state == ST_FAULT);
            gbe_nreset_o <= (state == ST_RUN) || (state == ST_FAULT);
            gbe_coma_o   <= (state == ST_ABSENT) || (state == ST_SETTLE);
            alrm_led_o   <= tx_fault_o | lopc_o | (rx_los_o & (state == ST_RUN)) | (state == ST_FAULT);
        end
    end

    logic [LED_W-1:0] led_cnt;

    // LED looks one count ahead so it drops exactly when the count reaches zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            led_cnt  <= '0;
            rx_led_o <= 1'b0;
        end else if (rx_pkt_i) begin
            led_cnt  <= LED_LOAD;
            rx_led_o <= 1'b1;
        end else begin
            rx_led_o <= (led_cnt > LED_W'(1));
            if (led_cnt != '0)
                led_cnt <= led_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_mx_xgbe_port_ctrl.sv
// Bench for mx_xgbe_port_ctrl: LED table through a scoreboard queue, plus hand-written sequencing scenarios.
module tb_mx_xgbe_port_ctrl;

    localparam int DEB  = 4;
    localparam int RSTC = 8;
    localparam int HOLD = 16;
    localparam int LEDH = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mod_abs, rx_los, tx_fault, lopc, sw_tx_disable, sw_reset, rx_pkt;
    logic       tx_disable, xge_nreset, gbe_nreset, gbe_coma, alrm_led, rx_led;
    logic       mod_abs_deb, rx_los_deb, tx_fault_deb, lopc_deb;
    logic [2:0] state;
    logic [7:0] fault_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic pkt;
        logic led_next;
    } led_vec_t;

    led_vec_t vecs[$];
    logic     exp_q[$];

    mx_xgbe_port_ctrl #(
        .DEB_CYCLES(DEB), .RST_CYCLES(RSTC), .FAULT_HOLD(HOLD), .LED_HOLD(LEDH)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .mod_abs_i(mod_abs), .rx_los_i(rx_los), .tx_fault_i(tx_fault), .lopc_i(lopc),
        .sw_tx_disable_i(sw_tx_disable), .sw_reset_i(sw_reset), .rx_pkt_i(rx_pkt),
        .tx_disable_o(tx_disable), .xge_nreset_o(xge_nreset), .gbe_nreset_o(gbe_nreset),
        .gbe_coma_o(gbe_coma), .alrm_led_o(alrm_led), .rx_led_o(rx_led),
        .mod_abs_o(mod_abs_deb), .rx_los_o(rx_los_deb), .tx_fault_o(tx_fault_deb), .lopc_o(lopc_deb),
        .state_o(state), .fault_cnt_o(fault_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic wait_state(input int s, input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (int'(state) == s) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic load(input string p, input string l);
        for (int i = 0; i < p.len(); i++)
            vecs.push_back('{p[i] == "1", l[i] == "1"});
    endtask

    initial begin
        int n, n_mod, n_settle, n_reset, n_run, n_xge;

        // Per-cycle rx_pkt and expected rx_led in the following cycle.
        load("10010000000",  "11111111000");
        load("1000000",      "1111100");
        load("100001000000", "111111111100");
        load("11000000",     "11111100");

        mod_abs = 1'b1; rx_los = 1'b1; tx_fault = 1'b0; lopc = 1'b1;
        sw_tx_disable = 1'b0; sw_reset = 1'b0; rx_pkt = 1'b0;

        #1 rst = 1'b1;
        #1;
        check("rst_tx_disable", tx_disable, 1);
        check("rst_xge_nreset", xge_nreset, 0);
        check("rst_gbe_nreset", gbe_nreset, 0);
        check("rst_gbe_coma", gbe_coma, 1);
        check("rst_alrm_led", alrm_led, 0);
        check("rst_rx_led", rx_led, 0);
        check("rst_state", state, 0);
        check("rst_fault_cnt", fault_cnt, 0);
        check("rst_mod_abs", mod_abs_deb, 1);
        check("rst_rx_los", rx_los_deb, 1);
        check("rst_tx_fault", tx_fault_deb, 0);
        check("rst_lopc", lopc_deb, 1);
        repeat (3) tick();
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            check("absent_tx_disable", tx_disable, 1);
            check("absent_xge_nreset", xge_nreset, 0);
            check("absent_state", state, 0);
        end

        check("led_idle", rx_led, 0);
        foreach (vecs[i]) begin
            rx_pkt = vecs[i].pkt;
            exp_q.push_back(vecs[i].led_next);
            tick();
            check("rx_led", rx_led, int'(exp_q.pop_front()));
        end
        rx_pkt = 1'b0;

        mod_abs = 1'b0;
        repeat (3) tick();
        mod_abs = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("glitch_mod_abs", mod_abs_deb, 1);
            check("glitch_state", state, 0);
        end

        // Cycle counts start at the drive cycle; 24 here is 23 after the first sampling edge.
        mod_abs = 1'b0; rx_los = 1'b0; lopc = 1'b0;
        n_mod = -1; n_settle = -1; n_reset = -1; n_run = -1; n_xge = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (n_mod < 0 && mod_abs_deb == 1'b0) n_mod = i;
            if (n_settle < 0 && state == 3'd1) n_settle = i;
            if (n_reset < 0 && state == 3'd2) n_reset = i;
            if (n_run < 0 && state == 3'd3) n_run = i;
            if (xge_nreset == 1'b1) begin
                n_xge = i;
                break;
            end
        end
        check("ins_mod_abs_fall", n_mod, 2 + DEB);
        check("ins_settle", n_settle, 2 + DEB + 1);
        check("ins_reset", n_reset, 2 + DEB + 1 + RSTC);
        check("ins_run", n_run, 2 + DEB + 1 + 2 * RSTC);
        check("ins_xge_nreset", n_xge, 2 + DEB + 1 + 2 * RSTC + 1);
        check("run_gbe_nreset", gbe_nreset, 1);
        check("run_tx_disable", tx_disable, 0);
        check("run_gbe_coma", gbe_coma, 0);
        check("run_alrm_led", alrm_led, 0);

        sw_tx_disable = 1'b1;
        tick();
        check("sw_tx_disable_on", tx_disable, 1);
        sw_tx_disable = 1'b0;
        tick();
        check("sw_tx_disable_off", tx_disable, 0);

        // A second sw_reset mid-RESET restarts the full RST_CYCLES count.
        sw_reset = 1'b1;
        tick();
        sw_reset = 1'b0;
        check("swrst_state", state, 2);
        repeat (3) tick();
        check("swrst_xge_nreset", xge_nreset, 0);
        check("swrst_tx_disable", tx_disable, 0);
        sw_reset = 1'b1;
        tick();
        sw_reset = 1'b0;
        wait_state(3, 30, n);
        check("swrst_restart_len", n, RSTC);

        tx_fault = 1'b1;
        wait_state(4, 30, n);
        check("fault_entry", n, 2 + DEB + 1);
        tx_fault = 1'b0;
        tick();
        check("fault_tx_disable", tx_disable, 1);
        check("fault_xge_nreset", xge_nreset, 1);
        check("fault_cnt_one", fault_cnt, 1);
        check("fault_alrm_led", alrm_led, 1);
`ifdef MX_XGBE_PORT_CTRL_FAULT_RETRY_EN
        wait_state(2, 40, n);
        check("fault_retry", n, HOLD - 1);
`else
        repeat (30) tick();
        check("fault_sticky", state, 4);
        sw_reset = 1'b1;
        tick();
        sw_reset = 1'b0;
        check("fault_swrst", state, 2);
`endif
        wait_state(3, 40, n);
        check("fault_back_run", n, RSTC);
        check("fault_cnt_hold", fault_cnt, 1);

        // Removal lands after RESET has already expired into RUN; removal beats sw_reset.
        sw_reset = 1'b1;
        tick();
        sw_reset = 1'b0;
        repeat (3) tick();
        mod_abs = 1'b1;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (mod_abs_deb == 1'b1) begin
                n = i;
                break;
            end
        end
        check("rm_mod_abs_rise", n, 2 + DEB);
        sw_reset = 1'b1;
        tick();
        sw_reset = 1'b0;
        check("rm_state", state, 0);
        tick();
        check("rm_tx_disable", tx_disable, 1);
        check("rm_gbe_coma", gbe_coma, 1);
        check("rm_xge_nreset", xge_nreset, 0);

        mod_abs = 1'b0;
        wait_state(3, 60, n);
        check("reins_run", n, 2 + DEB + 1 + 2 * RSTC);
        tick();
        #3 rst = 1'b1;
        #1;
        check("arst_xge_nreset", xge_nreset, 0);
        check("arst_tx_disable", tx_disable, 1);
        check("arst_state", state, 0);
        check("arst_mod_abs", mod_abs_deb, 1);
        check("arst_gbe_coma", gbe_coma, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_state(3, 60, n);
        check("arst_recover_run", n, 2 + DEB + 1 + 2 * RSTC);
        check("arst_fault_cnt", fault_cnt, 0);

        for (int i = 0; i < 300; i++) begin
            tx_fault = 1'b1;
            wait_state(4, 20, n);
            if (n < 0) begin
                check("sat_fault_entry", n, 2 + DEB + 1);
                break;
            end
            tx_fault = 1'b0;
`ifndef MX_XGBE_PORT_CTRL_FAULT_RETRY_EN
            for (int k = 0; k < 20 && tx_fault_deb; k++) tick();
            sw_reset = 1'b1;
            tick();
            sw_reset = 1'b0;
`endif
            wait_state(3, 60, n);
            if (n < 0) begin
                check("sat_back_run", n, RSTC);
                break;
            end
            if (i == 0)   check("sat_cnt_first", fault_cnt, 1);
            if (i == 254) check("sat_cnt_255", fault_cnt, 255);
        end
        check("sat_cnt_final", fault_cnt, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
